// File: rtl/pong_pkg.sv
// Shared types and constants for the pong ball engine.
package pong_pkg;

   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      PLAY   = 2'd1,
      SCORED = 2'd2
   } ball_state_t;

   localparam logic       DIR_RIGHT   = 1'b1;
   localparam logic       DIR_UP      = 1'b1;
   localparam logic [1:0] ZONE_CENTRE = 2'd0;
   localparam logic [1:0] ZONE_TOP    = 2'd1;
   localparam logic [1:0] ZONE_BOTTOM = 2'd2;

   function automatic int sat_add(input int a, input int b, input int lim);
      return (a + b > lim) ? lim : a + b;
   endfunction

endpackage

// File: rtl/pong_axis_step.sv
// One-axis signed position step, clamped to [LO, HI]; with REFLECT set the
// direction flips to point back into the field whenever a clamp limit is reached.
module pong_axis_step #(
   parameter int W       = 11,
   parameter int STEP_W  = 4,
   parameter int LO      = 0,
   parameter int HI      = 1,
   parameter bit REFLECT = 1'b0
) (
   input  logic [W-1:0]      pos_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   output logic [W-1:0]      pos_o,
   output logic              dir_o
);

   localparam int SW = W + 2;
   localparam logic signed [SW-1:0] LO_S = SW'(LO);
   localparam logic signed [SW-1:0] HI_S = SW'(HI);

   logic signed [SW-1:0] pos_s, step_s, next_s;

   // Two guard bits keep a step past either end from wrapping.
   assign pos_s  = $signed({2'b00, pos_i});
   assign step_s = $signed({{(SW-STEP_W){1'b0}}, step_i});
   assign next_s = dir_i ? pos_s + step_s : pos_s - step_s;

   always_comb begin
      pos_o = next_s[W-1:0];
      dir_o = dir_i;
      if (next_s >= HI_S) begin
         pos_o = W'(HI);
         if (REFLECT) dir_o = 1'b0;
      end else if (next_s <= LO_S) begin
         pos_o = W'(LO);
         if (REFLECT) dir_o = 1'b1;
      end
   end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball controller: serve/play/score FSM, frame-tick motion, paddle speed ramp.
// Define PONG_SPIN_EN to let the paddle contact zone steer the y motion.
module pong_ball_engine
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH    = 11,
   parameter int MAX_X        = 640,
   parameter int MAX_Y        = 480,
   parameter int BALL_SPEED_X = 2,
   parameter int BALL_SPEED_Y = 2,
   parameter int BALL_RADIUS  = 4,
   parameter int EDGE_OFFSET  = 8,
   parameter int SPEED_STEP   = 1,
   parameter int MAX_SPEED    = 8,
   parameter int SERVE_TICKS  = 60,
   parameter int SCORE_HOLD   = 30
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pause,
   input  logic                           frame_tick,
   input  logic [1:0]                     paddle_hit,
   input  logic [1:0]                     paddle_zone,
   output logic [BIT_WIDTH-1:0]           ball_x,
   output logic [BIT_WIDTH-1:0]           ball_y,
   output logic                           x_dir,
   output logic                           y_dir,
   output logic [$clog2(MAX_SPEED+1)-1:0] speed_x,
   output logic [1:0]                     state,
   output logic [1:0]                     win
);

   localparam int SPD_W   = $clog2(MAX_SPEED + 1);
   localparam int CNT_MAX = (SERVE_TICKS > SCORE_HOLD) ? SERVE_TICKS : SCORE_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SW      = BIT_WIDTH + 2;
   localparam logic [BIT_WIDTH-1:0] CX = BIT_WIDTH'(MAX_X / 2);
   localparam logic [BIT_WIDTH-1:0] CY = BIT_WIDTH'(MAX_Y / 2);

   ball_state_t          state_q, state_d;
   logic [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic                 xdir_q, xdir_d, ydir_q, ydir_d;
   logic                 miss_right_q, miss_right_d;
   logic [SPD_W-1:0]     spdx_q, spdx_d, spdy_q, spdy_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           win_q, win_d;

   logic                 hit_acc, miss_r, miss_l;
   logic                 xdir_hit, ydir_hit, xdir_step, ydir_step;
   logic [SPD_W-1:0]     spdx_hit, spdy_hit;
   logic [BIT_WIDTH-1:0] x_step, y_step;
   logic signed [SW-1:0] x_s;

   // Only the paddle the ball is heading toward can return it.
   assign hit_acc  = xdir_q ? paddle_hit[0] : paddle_hit[1];
   assign xdir_hit = xdir_q ^ hit_acc;
   assign spdx_hit = hit_acc ? SPD_W'(sat_add(int'(spdx_q), SPEED_STEP, MAX_SPEED)) : spdx_q;

   assign x_s    = $signed({2'b00, x_q});
   assign miss_r = (x_s + SW'(BALL_RADIUS)) >= SW'(MAX_X);
   assign miss_l = x_s <= SW'(BALL_RADIUS);

`ifdef PONG_SPIN_EN
   localparam int SPIN_SPEED = (2 * BALL_SPEED_Y > MAX_SPEED) ? MAX_SPEED : 2 * BALL_SPEED_Y;

   always_comb begin
      ydir_hit = ydir_q;
      spdy_hit = spdy_q;
      if (hit_acc) begin
         case (paddle_zone)
            ZONE_TOP: begin
               spdy_hit = SPD_W'(SPIN_SPEED);
               ydir_hit = 1'b1;
            end
            ZONE_BOTTOM: begin
               spdy_hit = SPD_W'(SPIN_SPEED);
               ydir_hit = 1'b0;
            end
            default: spdy_hit = SPD_W'(BALL_SPEED_Y);
         endcase
      end
   end
`else
   logic unused_zone;
   assign unused_zone = ^paddle_zone;
   assign ydir_hit    = ydir_q;
   assign spdy_hit    = spdy_q;
`endif

   pong_axis_step #(
      .W(BIT_WIDTH), .STEP_W(SPD_W), .LO(BALL_RADIUS), .HI(MAX_X - BALL_RADIUS), .REFLECT(1'b0)
   ) u_x_step (
      .pos_i(x_q), .dir_i(xdir_hit), .step_i(spdx_hit), .pos_o(x_step), .dir_o(xdir_step)
   );

   pong_axis_step #(
      .W(BIT_WIDTH), .STEP_W(SPD_W), .LO(EDGE_OFFSET + BALL_RADIUS),
      .HI(MAX_Y - EDGE_OFFSET - BALL_RADIUS), .REFLECT(1'b1)
   ) u_y_step (
      .pos_i(y_q), .dir_i(ydir_hit), .step_i(spdy_hit), .pos_o(y_step), .dir_o(ydir_step)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      xdir_d       = xdir_q;
      ydir_d       = ydir_q;
      miss_right_d = miss_right_q;
      spdx_d       = spdx_q;
      spdy_d       = spdy_q;
      cnt_d        = cnt_q;
      win_d        = '0;
      if (frame_tick && !pause) begin
         case (state_q)
            SERVE: begin
               x_d = CX;
               y_d = CY;
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            PLAY: begin
               if (!hit_acc && (miss_r || miss_l)) begin
                  state_d      = SCORED;
                  cnt_d        = CNT_W'(SCORE_HOLD);
                  win_d        = {miss_r, !miss_r};
                  miss_right_d = miss_r;
               end else begin
                  x_d    = x_step;
                  y_d    = y_step;
                  xdir_d = xdir_step;
                  ydir_d = ydir_step;
                  spdx_d = spdx_hit;
                  spdy_d = spdy_hit;
               end
            end
            SCORED: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = SERVE;
                  x_d     = CX;
                  y_d     = CY;
                  xdir_d  = miss_right_q;
                  spdx_d  = SPD_W'(BALL_SPEED_X);
                  spdy_d  = SPD_W'(BALL_SPEED_Y);
                  cnt_d   = CNT_W'(SERVE_TICKS);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = SERVE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SERVE;
         x_q          <= CX;
         y_q          <= CY;
         xdir_q       <= DIR_RIGHT;
         ydir_q       <= DIR_UP;
         miss_right_q <= DIR_RIGHT;
         spdx_q       <= SPD_W'(BALL_SPEED_X);
         spdy_q       <= SPD_W'(BALL_SPEED_Y);
         cnt_q        <= CNT_W'(SERVE_TICKS);
         win_q        <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         xdir_q       <= xdir_d;
         ydir_q       <= ydir_d;
         miss_right_q <= miss_right_d;
         spdx_q       <= spdx_d;
         spdy_q       <= spdy_d;
         cnt_q        <= cnt_d;
         win_q        <= win_d;
      end
   end

   assign ball_x  = x_q;
   assign ball_y  = y_q;
   assign x_dir   = xdir_q;
   assign y_dir   = ydir_q;
   assign speed_x = spdx_q;
   assign state   = state_q;
   assign win     = win_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: expected snapshots queued per frame tick
// or probe, popped and compared by an independent monitor.
module tb_pong_ball_engine;

   localparam int W = 32;

   logic        clk, rst, pause, frame_tick;
   logic [1:0]  paddle_hit, paddle_zone;
   logic [10:0] ball_x, ball_y;
   logic        x_dir, y_dir;
   logic [3:0]  speed_x;
   logic [1:0]  state, win;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   bit           care_q[$];
   int           tests, fails;
   logic         probe, obs_q;
   event         async_probe;

   int hit_x[9]   = '{317, 321, 316, 322, 315, 323, 315, 323, 315};
   int hit_spd[9] = '{3, 4, 5, 6, 7, 8, 8, 8, 8};
   int hit_xd[9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
   int hit_pad[9] = '{1, 2, 1, 2, 1, 2, 1, 3, 3};

   pong_ball_engine dut (
      .clk(clk), .rst(rst), .pause(pause), .frame_tick(frame_tick),
      .paddle_hit(paddle_hit), .paddle_zone(paddle_zone),
      .ball_x(ball_x), .ball_y(ball_y), .x_dir(x_dir), .y_dir(y_dir),
      .speed_x(speed_x), .state(state), .win(win)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Snapshot layout: st[31:30] win[29:28] xd[27] yd[26] spd[25:22] x[21:11] y[10:0]
   function automatic logic [W-1:0] mk(input int st, input int w, input int x, input int y,
                                       input int xd, input int yd, input int spd);
      return {2'(st), 2'(w), 1'(xd), 1'(yd), 4'(spd), 11'(x), 11'(y)};
   endfunction

   function automatic logic [W-1:0] act_vec();
      return {state, win, x_dir, y_dir, speed_x, ball_x, ball_y};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   task automatic check_pop();
      logic [W-1:0] e, a;
      string        n;
      bit           c;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_empty: output observed, expected queue had 0 entries");
         return;
      end
      e = exp_q.pop_front();
      n = name_q.pop_front();
      c = care_q.pop_front();
      a = act_vec();
      if (c) begin
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL %s: got st=%0d win=%b x=%0d y=%0d xd=%b yd=%b spd=%0d, expected st=%0d win=%b x=%0d y=%0d xd=%b yd=%b spd=%0d",
                     n, a[31:30], a[29:28], a[21:11], a[10:0], a[27], a[26], a[25:22],
                     e[31:30], e[29:28], e[21:11], e[10:0], e[27], e[26], e[25:22]);
         end
      end
   endtask

   always @(posedge clk) obs_q <= frame_tick | probe;
   always @(negedge clk) if (obs_q) check_pop();
   always @(async_probe) check_pop();

   // ---------------- driver tasks ----------------
   task automatic push(input string n, input logic [W-1:0] v, input bit c);
      exp_q.push_back(v);
      name_q.push_back(n);
      care_q.push_back(c);
   endtask

   task automatic tick(input string n, input logic [W-1:0] v, input int hit, input int zone);
      push(n, v, 1'b1);
      frame_tick  = 1'b1;
      paddle_hit  = 2'(hit);
      paddle_zone = 2'(zone);
      @(posedge clk);
      #1;
      frame_tick  = 1'b0;
      paddle_hit  = 2'b00;
      paddle_zone = 2'b00;
   endtask

   task automatic idle_probe(input string n, input logic [W-1:0] v);
      push(n, v, 1'b1);
      probe = 1'b1;
      @(posedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic async_reset_check(input string n, input logic [W-1:0] v);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #2;
      push(n, v, 1'b1);
      -> async_probe;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic serve_to_play(input int yd);
      for (int i = 1; i <= 59; i++)
         tick($sformatf("serve_%0d", i), mk(0, 0, 320, 240, 1, yd, 2), 0, 0);
      tick("serve_to_play", mk(1, 0, 320, 240, 1, yd, 2), 0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] rv, hold;
      tests = 0; fails = 0;
      probe = 1'b0; frame_tick = 1'b0; pause = 1'b0;
      paddle_hit = 2'b00; paddle_zone = 2'b00;
      rst = 1'b1;
      rv = mk(0, 0, 320, 240, 1, 1, 2);

      async_reset_check("reset_values", rv);
      idle_probe("reset_hold", rv);

      serve_to_play(1);
      for (int k = 1; k <= 113; k++)
         tick($sformatf("play_up_%0d", k), mk(1, 0, 320 + 2*k, 240 + 2*k, 1, 1, 2), 0, 0);
      tick("top_wall_clamp", mk(1, 0, 548, 468, 1, 0, 2), 0, 0);
      for (int k = 115; k <= 140; k++)
         tick($sformatf("play_down_%0d", k), mk(1, 0, 320 + 2*k, 468 - 2*(k - 114), 1, 0, 2), 0, 0);

      tick("right_paddle_hit", mk(1, 0, 597, 414, 0, 0, 3), 1, 0);
      tick("no_double_bounce", mk(1, 0, 594, 412, 0, 0, 3), 1, 0);
      hold = mk(1, 0, 594, 412, 0, 0, 3);
      idle_probe("no_tick_hold", hold);

      pause = 1'b1;
      for (int i = 1; i <= 10; i++)
         tick($sformatf("pause_hold_%0d", i), hold, 2, 0);
      pause = 1'b0;
      tick("after_pause", mk(1, 0, 591, 410, 0, 0, 3), 0, 0);

      tick("left_paddle_hit", mk(1, 0, 595, 408, 1, 0, 4), 2, 0);
      for (int m = 1; m <= 10; m++)
         tick($sformatf("run_right_%0d", m), mk(1, 0, 595 + 4*m, 408 - 2*m, 1, 0, 4), 0, 0);
      tick("right_x_clamp", mk(1, 0, 636, 386, 1, 0, 4), 0, 0);
      tick("right_miss_win", mk(2, 2, 636, 386, 1, 0, 4), 0, 0);
      idle_probe("win_one_cycle", mk(2, 0, 636, 386, 1, 0, 4));
      for (int i = 1; i <= 29; i++)
         tick($sformatf("scored_hold_%0d", i), mk(2, 0, 636, 386, 1, 0, 4), 0, 0);
      tick("scored_to_serve", mk(0, 0, 320, 240, 1, 0, 2), 0, 0);

      serve_to_play(0);
      tick("second_serve_move", mk(1, 0, 322, 238, 1, 0, 2), 0, 0);
      async_reset_check("async_reset_mid_play", rv);
      idle_probe("post_reset_hold", rv);

      serve_to_play(1);
      for (int i = 0; i < 9; i++) begin
`ifdef PONG_SPIN_EN
         tick($sformatf("hit_ramp_%0d", i + 1),
              mk(1, 0, hit_x[i], 236 - 2*i, hit_xd[i], 0, hit_spd[i]), hit_pad[i], (i == 0) ? 2 : 0);
`else
         tick($sformatf("hit_ramp_%0d", i + 1),
              mk(1, 0, hit_x[i], 242 + 2*i, hit_xd[i], 1, hit_spd[i]), hit_pad[i], (i == 0) ? 2 : 0);
`endif
      end

      repeat (3) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected end of stimulus");
      $fatal(1, "time limit");
   end

endmodule
